// File: rtl/uart_tx_pkg.sv
// Purpose: shared encodings for the UART transmit frame controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_pkg;

    // Default payload width; matches the bit serializer width.
    localparam int DATA_WIDTH_DEF = 8;

    // Line levels for the framing bits.
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Frame controller states. The encoding is 3 bits, so codes 5..7 are
    // unused and are recovered to IDLE.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_e;

endpackage

// File: rtl/tx_parity_calc.sv
// Purpose: registers the parity of a byte when load is high (even or odd per PAR_TYP).
// Latency: parity valid on the cycle after load.
// Backpressure: none; holds its value until the next load.
//
// Ports:
//   CLK     system clock, posedge
//   RST     synchronous active-low reset, clears parity to 0
//   data    byte to compute parity over
//   PAR_TYP 0 = even parity, 1 = odd parity
//   load    capture strobe (frame accept)
//   parity  registered parity bit
module tx_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  PAR_TYP,
    input  logic                  load,
    output logic                  parity
);

    logic parity_q;
    logic parity_d;

    always_comb begin
        parity_d = parity_q;
        if (load) begin
            // Even parity makes the total count of ones even, so the bit is
            // the XOR of the data; odd parity is its complement.
            parity_d = PAR_TYP ? ~^data : ^data;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    assign parity = parity_q;

endmodule

// File: rtl/uart_tx_ctrl.sv
// Purpose: UART transmit frame controller: start bit, LSB-first data, optional parity, stop bit(s).
// Latency: start bit begins 1 cycle after the accept edge; one bit per CLK.
// Backpressure: requests are taken only in IDLE; upstream holds Data_Valid until busy=0.
//
// Ports:
//   CLK        system clock (also the baud tick), posedge
//   RST        synchronous active-low reset; aborts any frame in progress
//   P_DATA     parallel byte, sampled at accept
//   Data_Valid request to send P_DATA
//   PAR_EN     insert a parity bit after the data (latched at accept)
//   PAR_TYP    0 = even, 1 = odd (latched at accept)
//   ser_data   current bit from the serializer, LSB first
//   ser_en     shift enable to the serializer, high only during data bits
//   busy       frame in progress; serializer loads only while low
//   TX_OUT     serial line, idle high
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic                  busy,
    output logic                  TX_OUT
);

    localparam int               CNT_W     = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    // STOP_BITS is 1 or 2, so a single-bit counter covers it.
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    state_e           state_q,    state_d;
    logic [CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic             stop_cnt_q, stop_cnt_d;
    logic             par_en_q,   par_en_d;
    logic             accept;
    logic             parity_bit;

    // Parity is captured in the accept cycle, alongside the serializer load,
    // so later PAR_TYP changes cannot affect the frame being sent.
    tx_parity_calc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_parity (
        .CLK     (CLK),
        .RST     (RST),
        .data    (P_DATA),
        .PAR_TYP (PAR_TYP),
        .load    (accept),
        .parity  (parity_bit)
    );

    // Next-state, bit counter and stop counter.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        accept     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (Data_Valid) begin
                    accept   = 1'b1;
                    par_en_d = PAR_EN;
                    state_d  = S_START;
                end
            end
            S_START: begin
                state_d = S_DATA;
            end
            S_DATA: begin
                if (bit_cnt_q == LAST_BIT) begin
                    bit_cnt_d = '0;
                    state_d   = par_en_q ? S_PARITY : S_STOP;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            S_PARITY: begin
                state_d = S_STOP;
            end
            S_STOP: begin
                if (stop_cnt_q == LAST_STOP) begin
                    stop_cnt_d = 1'b0;
                    state_d    = S_IDLE;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: begin
                // Unused encodings fall back to a clean idle.
                state_d    = S_IDLE;
                bit_cnt_d  = '0;
                stop_cnt_d = 1'b0;
            end
        endcase
    end

    // Outputs depend on the state register only (plus the serializer bit
    // passed through during data), so they are glitch-free per state.
    always_comb begin
        TX_OUT = STOP_BIT;
        busy   = 1'b0;
        ser_en = 1'b0;

        case (state_q)
            S_START: begin
                TX_OUT = START_BIT;
                busy   = 1'b1;
            end
            S_DATA: begin
                TX_OUT = ser_data;
                busy   = 1'b1;
                ser_en = 1'b1;
            end
            S_PARITY: begin
                TX_OUT = parity_bit;
                busy   = 1'b1;
            end
            S_STOP: begin
                TX_OUT = STOP_BIT;
                busy   = 1'b1;
            end
            default: begin
                TX_OUT = STOP_BIT;
                busy   = 1'b0;
                ser_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Purpose: directed self-checking bench for uart_tx_ctrl with a serializer model per instance.
// Latency: frames checked cycle by cycle from the start bit onward.
// Backpressure: requests are only raised while the DUT is idle, except the back-to-back case.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       dv2;
    logic       PAR_EN;
    logic       PAR_TYP;

    logic       ser_en1, busy1, tx1;
    logic       ser_en2, busy2, tx2;
    logic [7:0] sh1, sh2;
    logic       ser_data1, ser_data2;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Instance with one stop bit.
    uart_tx_ctrl #(
        .DATA_WIDTH (8),
        .STOP_BITS  (1)
    ) dut1 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data1),
        .ser_en     (ser_en1),
        .busy       (busy1),
        .TX_OUT     (tx1)
    );

    // Instance with two stop bits; has its own request line.
    uart_tx_ctrl #(
        .DATA_WIDTH (8),
        .STOP_BITS  (2)
    ) dut2 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (dv2),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .ser_data   (ser_data2),
        .ser_en     (ser_en2),
        .busy       (busy2),
        .TX_OUT     (tx2)
    );

    // Serializer models: load while not busy on a request, shift right on ser_en.
    always @(posedge CLK) begin
        if (!busy1 && Data_Valid) sh1 <= P_DATA;
        else if (ser_en1)         sh1 <= {1'b0, sh1[7:1]};
    end
    always @(posedge CLK) begin
        if (!busy2 && dv2) sh2 <= P_DATA;
        else if (ser_en2)  sh2 <= {1'b0, sh2[7:1]};
    end
    assign ser_data1 = sh1[0];
    assign ser_data2 = sh2[0];

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Checks a frame starting at its start-bit cycle. exp holds the line
    // levels with the first bit in position len-1. Ends on the cycle after
    // the frame, which must be idle.
    task automatic check_frame(input logic sel, input logic [15:0] exp,
                               input int len, input string tag);
        for (int i = 1; i <= len; i++) begin
            chk({tag, "_tx"},     sel ? tx2 : tx1,         exp[len-i]);
            chk({tag, "_busy"},   sel ? busy2 : busy1,     1'b1);
            chk({tag, "_ser_en"}, sel ? ser_en2 : ser_en1, (i >= 2 && i <= 9) ? 1'b1 : 1'b0);
            step();
        end
        chk({tag, "_idle_tx"},   sel ? tx2 : tx1,     1'b1);
        chk({tag, "_idle_busy"}, sel ? busy2 : busy1, 1'b0);
    endtask

    task automatic run_frame(input logic sel, input logic [7:0] d, input logic pe,
                             input logic pt, input logic [15:0] exp, input int len,
                             input string tag);
        P_DATA  = d;
        PAR_EN  = pe;
        PAR_TYP = pt;
        if (sel) dv2 = 1'b1;
        else     Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        dv2        = 1'b0;
        check_frame(sel, exp, len, tag);
    endtask

    initial begin
        RST        = 1'b0;
        Data_Valid = 1'b1;
        dv2        = 1'b1;
        P_DATA     = 8'h5A;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;

        // Reset held with a pending request: outputs stay idle.
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_tx",     tx1,     1'b1);
            chk("rst_busy",   busy1,   1'b0);
            chk("rst_ser_en", ser_en1, 1'b0);
            chk("rst_tx2",    tx2,     1'b1);
        end
        RST        = 1'b1;
        Data_Valid = 1'b0;
        dv2        = 1'b0;
        step();

        // 0xA5 without parity: 0 10100101(LSB first) 1
        run_frame(1'b0, 8'hA5, 1'b0, 1'b0, 16'b0101001011, 10, "a5_nopar");
        // 0xA5 has four ones: even parity 0, odd parity 1
        run_frame(1'b0, 8'hA5, 1'b1, 1'b0, 16'b01010010101, 11, "a5_even");
        run_frame(1'b0, 8'hA5, 1'b1, 1'b1, 16'b01010010111, 11, "a5_odd");

        // Back-to-back with the request held; P_DATA changes mid-frame.
        PAR_EN     = 1'b0;
        P_DATA     = 8'h01;
        Data_Valid = 1'b1;
        step();
        P_DATA = 8'hFF;
        check_frame(1'b0, 16'b0100000001, 10, "b2b_01");
        step();
        Data_Valid = 1'b0;
        check_frame(1'b0, 16'b0111111111, 10, "b2b_ff");

        // Reset during the fourth data bit.
        P_DATA     = 8'hA5;
        PAR_EN     = 1'b0;
        Data_Valid = 1'b1;
        step();
        Data_Valid = 1'b0;
        for (int c = 0; c < 4; c++) step();
        chk("mid_data_bit3", tx1, 1'b0);
        RST = 1'b0;
        step();
        chk("abort_tx",     tx1,     1'b1);
        chk("abort_busy",   busy1,   1'b0);
        chk("abort_ser_en", ser_en1, 1'b0);
        RST = 1'b1;
        step();
        chk("abort_idle_busy", busy1, 1'b0);
        run_frame(1'b0, 8'hA5, 1'b0, 1'b0, 16'b0101001011, 10, "after_abort");

        // Two stop bits; parity settings changed right after accept.
        // 0x07 has three ones: even parity (accept-time) is 1.
        P_DATA  = 8'h07;
        PAR_EN  = 1'b1;
        PAR_TYP = 1'b0;
        dv2     = 1'b1;
        step();
        dv2     = 1'b0;
        PAR_TYP = 1'b1;
        PAR_EN  = 1'b0;
        check_frame(1'b1, 16'b011100000111, 12, "stop2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
